// File: rtl/apb_arb_pkg.sv
// Shared widths, defaults and FSM encoding for the APB request arbiter.
package apb_arb_pkg;

    localparam int ADDR_W             = 9;
    localparam int DATA_W             = 8;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Index width that stays at least one bit for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int N     = DEF_NUM_REQ,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters.
// Optional busy timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_rw,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]                rsp_rdata,
    output logic                             rsp_err,
    output logic                             transfer,
    output logic                             READ_WRITE,
    output logic [ADDR_W-1:0]                apb_write_paddr,
    output logic [ADDR_W-1:0]                apb_read_paddr,
    output logic [DATA_W-1:0]                apb_write_data,
    input  logic [DATA_W-1:0]                apb_read_data_out,
    input  logic                             PSLVERR,
    input  logic                             xfer_done
);

    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_req_arbiter: NUM_REQ and TIMEOUT_CYCLES must be at least 1");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                grant_en;

    apb_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Reset is folded in so the grant pulse is silent while PRESETn is low.
    assign grant_en = (state_q == ST_IDLE) && pick_any && PRESETn;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_BUSY;
                    win_d   = pick_idx;
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    rw_d    = req_rw[pick_idx];
                    addr_d  = req_addr[pick_idx];
                    wdata_d = req_wdata[pick_idx];
                end
            end
            ST_BUSY: begin
                if (xfer_done) begin
                    state_d = ST_RESP;
                    rdata_d = rw_q ? apb_read_data_out : '0;
                    err_d   = PSLVERR;
`ifdef APB_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            // NOTE: payload registers are reset as well so no output can ever carry X.
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready       = grant_en ? pick_grant : '0;
    assign transfer        = (state_q == ST_BUSY);
    assign READ_WRITE      = transfer & rw_q;
    assign apb_read_paddr  = (transfer &&  rw_q) ? addr_q  : '0;
    assign apb_write_paddr = (transfer && !rw_q) ? addr_q  : '0;
    assign apb_write_data  = (transfer && !rw_q) ? wdata_q : '0;
    assign rsp_valid       = (state_q == ST_RESP) ? (NUM_REQ'(1) << win_q) : '0;
    assign rsp_rdata       = (state_q == ST_RESP) ? rdata_q : '0;
    assign rsp_err         = (state_q == ST_RESP) & err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter; checks follow APB_ARB_TIMEOUT_EN when defined.
module tb_apb_req_arbiter;

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic [3:0]       req_valid, req_rw;
    logic [3:0][8:0]  req_addr;
    logic [3:0][7:0]  req_wdata;
    logic [3:0]       req_ready, rsp_valid;
    logic [7:0]       rsp_rdata;
    logic             rsp_err;
    logic             transfer, READ_WRITE;
    logic [8:0]       apb_write_paddr, apb_read_paddr;
    logic [7:0]       apb_write_data, apb_read_data_out;
    logic             PSLVERR, xfer_done;

    int n_checks = 0;
    int n_fail   = 0;

    apb_req_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .req_valid         (req_valid),
        .req_rw            (req_rw),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_data_out (apb_read_data_out),
        .PSLVERR           (PSLVERR),
        .xfer_done         (xfer_done)
    );

    always #5 PCLK = ~PCLK;

    logic [44:0] all_out;
    assign all_out = {transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
                      req_ready, rsp_valid, rsp_rdata, rsp_err};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESETn           = 1'b0;
        req_valid         = '0;
        req_rw            = '0;
        req_addr          = '0;
        req_wdata         = '0;
        apb_read_data_out = '0;
        PSLVERR           = 1'b0;
        xfer_done         = 1'b0;

        // Reset state and silence of req_ready while held in reset.
        #1;
        check("reset_outputs", 64'(all_out), 64'd0);
        req_valid = 4'hF;
        #1;
        check("reset_no_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        step();
        step();
        PRESETn = 1'b1;
        #1;
        check("idle_outputs", 64'(all_out), 64'd0);

        // Single write from requester 0, xfer_done three cycles into transfer.
        req_valid[0] = 1'b1;
        req_rw[0]    = 1'b0;
        req_addr[0]  = 9'h005;
        req_wdata[0] = 8'hA5;
        #1;
        check("wr_grant", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        check("wr_transfer", 64'(transfer), 64'd1);
        check("wr_dir", 64'(READ_WRITE), 64'd0);
        check("wr_paddr", 64'(apb_write_paddr), 64'h005);
        check("wr_data", 64'(apb_write_data), 64'hA5);
        check("wr_rpaddr", 64'(apb_read_paddr), 64'd0);
        step();
        check("wr_hold_paddr", 64'(apb_write_paddr), 64'h005);
        step();
        check("wr_hold_data", 64'(apb_write_data), 64'hA5);
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        check("wr_rsp_valid", 64'(rsp_valid), 64'h1);
        check("wr_rsp_err", 64'(rsp_err), 64'd0);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("wr_resp_notransfer", 64'(transfer), 64'd0);
        step();
        check("wr_back_idle", 64'(all_out), 64'd0);

        // Single read from requester 2 at the top address.
        req_valid[2] = 1'b1;
        req_rw[2]    = 1'b1;
        req_addr[2]  = 9'h1FF;
        #1;
        check("rd_grant", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        check("rd_dir", 64'(READ_WRITE), 64'd1);
        check("rd_paddr", 64'(apb_read_paddr), 64'h1FF);
        check("rd_wpaddr", 64'(apb_write_paddr), 64'd0);
        check("rd_wdata", 64'(apb_write_data), 64'd0);
        xfer_done         = 1'b1;
        apb_read_data_out = 8'h3C;
        step();
        xfer_done         = 1'b0;
        apb_read_data_out = 8'h00;
        check("rd_rsp_valid", 64'(rsp_valid), 64'h4);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'h3C);
        step();
        check("rd_rdata_cleared", 64'(rsp_rdata), 64'd0);

        // Slave error on requester 1, then the next grant is unaffected (pointer at 2).
        req_valid[1] = 1'b1;
        req_addr[1]  = 9'h0AA;
        req_wdata[1] = 8'h11;
        #1;
        check("err_grant", 64'(req_ready), 64'h2);
        step();
        req_valid = '0;
        xfer_done = 1'b1;
        PSLVERR   = 1'b1;
        step();
        xfer_done = 1'b0;
        PSLVERR   = 1'b0;
        check("err_rsp_valid", 64'(rsp_valid), 64'h2);
        check("err_rsp_err", 64'(rsp_err), 64'd1);
        step();
        check("err_cleared", 64'(rsp_err), 64'd0);
        req_valid = 4'b1010;
        #1;
        check("after_err_grant", 64'(req_ready), 64'h8);
        step();
        req_valid = '0;
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        check("after_err_rsp_valid", 64'(rsp_valid), 64'h8);
        check("after_err_rsp_err", 64'(rsp_err), 64'd0);
        step();

        // Contention: all requesters reading continuously from reset.
        PRESETn   = 1'b0;
        req_valid = 4'hF;
        req_rw    = 4'hF;
        #1;
        step();
        PRESETn = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("rr_grant%0d", g), 64'(req_ready), 64'(4'b0001 << (g % 4)));
            step();
            check($sformatf("rr_busy_noready%0d", g), 64'(req_ready), 64'd0);
            xfer_done         = 1'b1;
            apb_read_data_out = 8'(g + 1);
            step();
            xfer_done = 1'b0;
            check($sformatf("rr_rsp%0d", g), 64'(rsp_valid), 64'(4'b0001 << (g % 4)));
            check($sformatf("rr_rdata%0d", g), 64'(rsp_rdata), 64'(g + 1));
            step();
        end
        req_valid = 4'b0001;

        // Busy with no xfer_done (pointer at 1, only requester 0 reading).
        #1;
        check("to_grant", 64'(req_ready), 64'h1);
        step();
        req_valid         = '0;
        apb_read_data_out = 8'h77;
`ifdef APB_ARB_TIMEOUT_EN
        repeat (15) step();
        check("to_still_busy", 64'(transfer), 64'd1);
        step();
        check("to_transfer_drop", 64'(transfer), 64'd0);
        check("to_rsp_valid", 64'(rsp_valid), 64'h1);
        check("to_rsp_err", 64'(rsp_err), 64'd1);
        check("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        step();
`else
        repeat (20) step();
        check("nto_still_busy", 64'(transfer), 64'd1);
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        check("nto_rsp_valid", 64'(rsp_valid), 64'h1);
        check("nto_rsp_err", 64'(rsp_err), 64'd0);
        check("nto_rsp_rdata", 64'(rsp_rdata), 64'h77);
        step();
`endif

        // Reset two cycles after a grant abandons the transfer.
        req_valid    = 4'b0100;
        req_rw[2]    = 1'b0;
        req_wdata[2] = 8'h5A;
        #1;
        check("rst_grant", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        check("rst_busy", 64'(transfer), 64'd1);
        step();
        PRESETn   = 1'b0;
        xfer_done = 1'b1;
        #1;
        check("rst_async_outputs", 64'(all_out), 64'd0);
        step();
        check("rst_no_rsp_a", 64'(rsp_valid), 64'd0);
        step();
        xfer_done = 1'b0;
        PRESETn   = 1'b1;
        #1;
        check("rst_no_rsp_b", 64'(all_out), 64'd0);
        req_valid = 4'hF;
        #1;
        check("rst_ptr_zero", 64'(req_ready), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one APB master.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait for completion per transfer.
REQ-003 SHALL have port PCLK  input  1  clock; one clock only, all logic on its rising edge.
REQ-004 SHALL have port PRESETn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester request pending.
REQ-006 SHALL have port req_rw  input  NUM_REQ  per-requester direction; 1 = read, 0 = write.
REQ-007 SHALL have port req_addr  input  NUM_REQ x 9  per-requester address.
REQ-008 SHALL have port req_wdata  input  NUM_REQ x 8  per-requester write data.
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot single-cycle grant/accept pulse.
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot single-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  8  read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err  output  1  slave error or timeout, valid with rsp_valid.
REQ-013 SHALL have ports transfer, READ_WRITE (1 each), apb_write_paddr, apb_read_paddr (9 each), apb_write_data (8)  outputs  APB master request side.
REQ-014 SHALL have ports apb_read_data_out (8), PSLVERR (1)  inputs  APB master results.
REQ-015 SHALL have port xfer_done  input  1  one-cycle pulse when the master's access phase completes.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-017 In IDLE with any req_valid high, SHALL pick a winner round-robin from priority pointer, pulse req_ready[winner] that cycle, capture rw/addr/wdata, go BUSY.
REQ-018 After granting index i, pointer SHALL become (i+1) mod NUM_REQ; a sole requester is re-granted.
REQ-019 In BUSY, transfer SHALL be 1 and all request outputs SHALL hold the captured values unchanged.
REQ-020 Reads: READ_WRITE=1, apb_read_paddr=addr, apb_write_paddr=0, apb_write_data=0; writes: READ_WRITE=0, apb_write_paddr=addr, apb_write_data=wdata, apb_read_paddr=0; outputs never X.
REQ-021 On xfer_done in BUSY, SHALL register apb_read_data_out (reads; 0 for writes) and PSLVERR, go RESP.
REQ-022 In RESP, transfer=0, rsp_valid[winner]=1, rsp_rdata/rsp_err driven; next state IDLE.
REQ-023 Latency: grant cycle N, transfer high N+1 .. D (xfer_done sampled at D), rsp_valid at D+1, earliest next grant D+2.
REQ-024 xfer_done outside BUSY SHALL be ignored; req_valid changes outside IDLE SHALL be ignored.
REQ-025 Requester SHALL hold req_valid and payload stable until req_ready; arbiter captures only at grant.
REQ-026 rsp_rdata and rsp_err SHALL be 0 when rsp_valid is all-zero.

Reset
REQ-027 PRESETn low SHALL immediately force IDLE, pointer 0, timeout counter 0, all outputs 0.
REQ-028 Reset mid-BUSY SHALL abandon the transfer with no rsp_valid issued.

Configuration
REQ-029 With APB_ARB_TIMEOUT_EN defined, BUSY SHALL count cycles; at TIMEOUT_CYCLES without xfer_done, go RESP with rsp_err=1, rsp_rdata=0; xfer_done in the same cycle as expiry takes precedence.
REQ-030 Without APB_ARB_TIMEOUT_EN, no counter SHALL exist and BUSY waits indefinitely for xfer_done.

Structure
REQ-031 Package apb_arb_pkg SHALL hold ADDR_W=9, DATA_W=8, the FSM state enum and the default NUM_REQ/TIMEOUT_CYCLES.
REQ-032 Round-robin selection SHALL live in sub-module apb_rr_picker (req vector + pointer in, one-hot grant + index out, combinational).

Verification
REQ-033 Single write: req 0 write addr 0x05 data 0xA5, xfer_done 3 cycles after transfer -> apb_write_paddr=0x05, apb_write_data=0xA5 stable while transfer, rsp_valid[0], rsp_err=0.
REQ-034 Single read: req 2 read addr 0x1FF, apb_read_data_out=0x3C at xfer_done -> rsp_valid[2], rsp_rdata=0x3C, apb_write_* = 0.
REQ-035 Contention: all four valid continuously from reset -> grant order 0,1,2,3,0 with one rsp per grant.
REQ-036 Error: PSLVERR=1 with xfer_done on req 1 -> rsp_err=1 on rsp_valid[1]; next grant unaffected.
REQ-037 Timeout (APB_ARB_TIMEOUT_EN): no xfer_done -> transfer drops after 16 BUSY cycles, rsp_err=1, rsp_rdata=0; without macro transfer stays high.
REQ-038 Reset mid-BUSY: PRESETn low 2 cycles after grant -> outputs 0 asynchronously, no rsp_valid, next grant goes to requester 0.
